// File: rtl/prog_clkdiv.sv
// Multi-channel programmable clock divider: each channel counts enabled cycles
// up to its divisor and emits a terminal-count tick plus a square or pulse output.
module prog_clkdiv #(
  parameter int          NCH         = 2,
  parameter int          CW          = 28,
  parameter int unsigned DEFAULT_DIV = 500000
) (
  input  logic              clk100Mhz,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic              div_load,
  input  logic [2:0]        div_sel,
  input  logic [CW-1:0]     div_value,
  input  logic              mode_in,
  input  logic              sync_all,
  output logic [NCH-1:0]    slow_clk,
  output logic [NCH-1:0]    tick,
  output logic              load_err
);

  localparam logic [CW-1:0] DefDiv = CW'(DEFAULT_DIV);

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  div_q [NCH];
  logic [CW-1:0]  div_d [NCH];
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] slow_q, slow_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic           loadErr_q, loadErr_d;
  logic           loadOk;

  // A divisor of zero behaves like a divisor of one.
  function automatic logic [CW-1:0] effDiv(input logic [CW-1:0] d);
    return (d == '0) ? CW'(1) : d;
  endfunction

  always_comb begin
    loadOk    = div_load && (32'(div_sel) < NCH);
    loadErr_d = div_load && !loadOk;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      mode_d[i] = mode_q[i];
      slow_d[i] = slow_q[i];
      tick_d[i] = 1'b0;
      // Using >= makes a counter stranded above a lowered divisor wrap at once.
      if (en[i]) begin
        if (cnt_q[i] >= effDiv(div_q[i]) - CW'(1)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          slow_d[i] = mode_q[i] ? 1'b1 : ~slow_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
          if (mode_q[i]) slow_d[i] = 1'b0;
        end
      end
      if (loadOk && (div_sel == 3'(i))) begin
        div_d[i]  = div_value;
        mode_d[i] = mode_in;
        cnt_d[i]  = '0;
        slow_d[i] = 1'b0;
        tick_d[i] = 1'b0;
      end
      if (sync_all) begin
        cnt_d[i]  = '0;
        slow_d[i] = 1'b0;
        tick_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DefDiv;
      end
      mode_q    <= '0;
      slow_q    <= '0;
      tick_q    <= '0;
      loadErr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      slow_q    <= slow_d;
      tick_q    <= tick_d;
      loadErr_q <= loadErr_d;
    end
  end

  assign slow_clk = slow_q;
  assign tick     = tick_q;
  assign load_err = loadErr_q;

endmodule

// File: tb/tb_prog_clkdiv.sv
// Self-checking bench for prog_clkdiv: vector table, directed corner sequences
// and a randomized run compared against a phase-count reference model.
module tb_prog_clkdiv;

  localparam int NCH = 2;
  localparam int CW  = 28;
  localparam int DEF = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           div_load;
  logic [2:0]     div_sel;
  logic [CW-1:0]  div_value;
  logic           mode_in;
  logic           sync_all;
  logic [NCH-1:0] slow_clk;
  logic [NCH-1:0] tick;
  logic           load_err;

  int nTests = 0;
  int nFail  = 0;

  // Model: each channel is described by how many enabled cycles have elapsed
  // since it was last cleared; tick and slow_clk follow arithmetically from that.
  int phase [NCH];
  int dEff  [NCH];
  int mMode [NCH];
  bit lastEn[NCH];
  bit mLerr;

  prog_clkdiv #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEF)) dut (
    .clk100Mhz(clk), .rst(rst), .en(en), .div_load(div_load), .div_sel(div_sel),
    .div_value(div_value), .mode_in(mode_in), .sync_all(sync_all),
    .slow_clk(slow_clk), .tick(tick), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic       ld;
    logic [2:0] sel;
    int         val;
    logic       md;
    logic       sy;
    logic [1:0] expTick;
    logic [1:0] expSlow;
    logic       expErr;
  } vec_t;

  function automatic logic [NCH-1:0] modelTick();
    logic [NCH-1:0] t;
    for (int i = 0; i < NCH; i++)
      t[i] = lastEn[i] && phase[i] > 0 && (phase[i] % dEff[i]) == 0;
    return t;
  endfunction

  function automatic logic [NCH-1:0] modelSlow();
    logic [NCH-1:0] s;
    for (int i = 0; i < NCH; i++) begin
      if (mMode[i] != 0) s[i] = phase[i] > 0 && (phase[i] % dEff[i]) == 0;
      else               s[i] = ((phase[i] / dEff[i]) % 2) == 1;
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        phase[i] = 0; dEff[i] = DEF; mMode[i] = 0; lastEn[i] = 0;
      end
      mLerr = 0;
    end else begin
      mLerr = div_load && (div_sel >= NCH);
      for (int i = 0; i < NCH; i++) begin
        lastEn[i] = en[i];
        if (en[i]) phase[i]++;
        if (div_load && div_sel == 3'(i)) begin
          dEff[i]  = (div_value == 0) ? 1 : int'(div_value);
          mMode[i] = int'(mode_in);
          phase[i] = 0;
        end
        if (sync_all) phase[i] = 0;
      end
    end
  endtask

  task automatic checkOutput();
    check("model tick", 32'(tick), 32'(modelTick()));
    check("model slow_clk", 32'(slow_clk), 32'(modelSlow()));
    check("model load_err", 32'(load_err), 32'(mLerr));
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] e, input logic ld,
                               input logic [2:0] sel, input int val, input logic m,
                               input logic s);
    rst = r; en = e; div_load = ld; div_sel = sel;
    div_value = CW'(val); mode_in = m; sync_all = s;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic run(input logic [1:0] e, input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, e, 0, 0, 0, 0, 0);
  endtask

  vec_t vecs[10];
  int   tickTimes[$];
  logic held;
  int   waitCnt;

  initial begin
    rst = 1; en = '0; div_load = 0; div_sel = '0; div_value = '0; mode_in = 0; sync_all = 0;

    // Reset state, with a load and sync that reset must override.
    applyStimulus(1, 2'b11, 0, 0, 0, 0, 0);
    applyStimulus(1, 2'b11, 1, 0, 3, 1, 1);
    check("reset tick", 32'(tick), 0);
    check("reset slow_clk", 32'(slow_clk), 0);
    check("reset load_err", 32'(load_err), 0);

    // Hand-derived vector table, starting from the reset state.
    vecs[0] = '{2'b00, 1, 3'd0, 2, 0, 0, 2'b00, 2'b00, 0};
    vecs[1] = '{2'b01, 1, 3'd1, 1, 1, 0, 2'b00, 2'b00, 0};
    vecs[2] = '{2'b11, 0, 3'd0, 0, 0, 0, 2'b11, 2'b11, 0};
    vecs[3] = '{2'b11, 0, 3'd0, 0, 0, 0, 2'b10, 2'b11, 0};
    vecs[4] = '{2'b10, 0, 3'd0, 0, 0, 0, 2'b10, 2'b11, 0};
    vecs[5] = '{2'b11, 1, 3'd5, 9, 1, 0, 2'b11, 2'b10, 1};
    vecs[6] = '{2'b11, 0, 3'd0, 0, 0, 1, 2'b00, 2'b00, 0};
    vecs[7] = '{2'b01, 1, 3'd0, 0, 0, 0, 2'b00, 2'b00, 0};
    vecs[8] = '{2'b01, 0, 3'd0, 0, 0, 0, 2'b01, 2'b01, 0};
    vecs[9] = '{2'b01, 0, 3'd0, 0, 0, 0, 2'b01, 2'b00, 0};
    for (int v = 0; v < 10; v++) begin
      applyStimulus(0, vecs[v].en, vecs[v].ld, vecs[v].sel, vecs[v].val, vecs[v].md, vecs[v].sy);
      check($sformatf("vec%0d tick", v), 32'(tick), 32'(vecs[v].expTick));
      check($sformatf("vec%0d slow_clk", v), 32'(slow_clk), 32'(vecs[v].expSlow));
      check($sformatf("vec%0d load_err", v), 32'(load_err), 32'(vecs[v].expErr));
    end

    // Default divisor: ticks every DEF cycles, slow_clk toggles on each tick.
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0);
    tickTimes.delete();
    for (int c = 1; c <= 2 * DEF + 2; c++) begin
      applyStimulus(0, 2'b11, 0, 0, 0, 0, 0);
      if (tick[0]) tickTimes.push_back(c);
      if (c == DEF)     check("default first toggle", 32'(slow_clk), 32'b11);
      if (c == 2 * DEF) check("default second toggle", 32'(slow_clk), 32'b00);
    end
    check("default tick count", tickTimes.size(), 2);
    if (tickTimes.size() >= 2) begin
      check("default first tick", tickTimes[0], DEF);
      check("default tick spacing", tickTimes[1] - tickTimes[0], DEF);
    end

    // Freeze ch0 mid-count, then resume from the held count.
    applyStimulus(0, 2'b11, 1, 0, 5, 0, 0);
    run(2'b11, 2);
    held = slow_clk[0];
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 2'b10, 0, 0, 0, 0, 0);
      check("frozen tick", 32'(tick[0]), 0);
      check("frozen slow_clk", 32'(slow_clk[0]), 32'(held));
    end
    waitCnt = 0;
    do begin
      applyStimulus(0, 2'b11, 0, 0, 0, 0, 0);
      waitCnt++;
    end while (!tick[0] && waitCnt < 10);
    check("resume tick delay", waitCnt, 3);

    // Sync alignment: div 3 and 6 tick together six cycles after sync.
    applyStimulus(0, 2'b11, 1, 0, 3, 0, 0);
    applyStimulus(0, 2'b11, 1, 1, 6, 0, 0);
    run(2'b11, 4);
    applyStimulus(0, 2'b11, 0, 0, 0, 0, 1);
    check("sync clears", 32'({tick, slow_clk}), 0);
    run(2'b11, 5);
    applyStimulus(0, 2'b11, 0, 0, 0, 0, 0);
    check("aligned tick", 32'(tick), 32'b11);
    // Load and sync together on a terminal cycle of ch0: no tick anywhere.
    run(2'b11, 2);
    applyStimulus(0, 2'b11, 1, 0, 3, 1, 1);
    check("load+sync at terminal", 32'({tick, slow_clk}), 0);
    // Load alone on ch0's terminal cycle suppresses its tick.
    run(2'b11, 2);
    applyStimulus(0, 2'b11, 1, 0, 3, 0, 0);
    check("load at terminal", 32'(tick[0]), 0);
    // Reset on a terminal cycle leaves no residual tick.
    run(2'b11, 2);
    applyStimulus(1, 2'b11, 0, 0, 0, 0, 0);
    check("reset at terminal", 32'(tick), 0);

    // Randomized run against the model.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(63) == 0), 2'($urandom), ($urandom_range(7) == 0),
                    3'($urandom), $urandom_range(7), 1'($urandom), ($urandom_range(31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
